// File: rtl/ride_request_queue.sv
// rtl/ride_request_queue.sv - ride request capture, validation and FIFO front-end for the elevator controller
//
// Purpose:
//   Captures ride requests submitted with a strobe that is asynchronous to clk,
//   checks that they are legal, buffers them in a FIFO and hands them to the
//   elevator controller over a valid/ready handshake.
//
// Ports:
//   clk              system clock, rising edge
//   rst              asynchronous active-high reset
//   set_clk          request strobe, asynchronous; a rising edge submits a request
//   src_input        request source floor
//   dest_input       request destination floor
//   direction_input  1 = up, 0 = down
//   out_valid        head entry available
//   out_ready        controller accepts the head entry
//   out_src          head source floor
//   out_dest         head destination floor
//   out_dir          head direction
//   count            number of stored entries
//   full             count == DEPTH
//   empty            count == 0
//   reject_pulse     one-cycle pulse when a submitted request is dropped
//   reject_code      reason for the last drop, held until the next drop

`timescale 1ns/1ps

module ride_request_queue #(
    parameter int DEPTH     = 4,
    parameter int MAX_FLOOR = 5,
    parameter int CW        = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          set_clk,
    input  logic [2:0]    src_input,
    input  logic [2:0]    dest_input,
    input  logic          direction_input,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [2:0]    out_src,
    output logic [2:0]    out_dest,
    output logic          out_dir,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty,
    output logic          reject_pulse,
    output logic [2:0]    reject_code
);

    localparam int         AW       = $clog2(DEPTH);
    localparam logic [2:0] MAX_FL   = 3'(MAX_FLOOR);

    localparam logic [2:0] RC_NONE  = 3'd0;
    localparam logic [2:0] RC_RANGE = 3'd1;
    localparam logic [2:0] RC_SAME  = 3'd2;
    localparam logic [2:0] RC_DIR   = 3'd3;
    localparam logic [2:0] RC_FULL  = 3'd4;
    localparam logic [2:0] RC_DUP   = 3'd5;

    // Entry storage, one array per field
    logic [2:0]    mem_src  [DEPTH];
    logic [2:0]    mem_dest [DEPTH];
    logic          mem_dir  [DEPTH];

    logic [AW-1:0] head_ptr;
    logic [AW-1:0] tail_ptr;
    logic [CW-1:0] count_q;

    // Strobe synchronizer (sync1, sync2) and edge-detect stage (sync3)
    logic          sync1;
    logic          sync2;
    logic          sync3;

    logic          push_req;
    logic          pop;
    logic          push_ok;
    logic [2:0]    check_code;
    logic          dup_hit;
    logic [AW-1:0] dup_off;
    logic          dup_live;

    assign push_req  = sync2 & ~sync3;
    assign out_valid = (count_q != '0);
    assign pop       = out_valid & out_ready;
    assign push_ok   = push_req && (check_code == RC_NONE);

    assign count     = count_q;
    assign empty     = (count_q == '0);
    assign full      = (count_q == CW'(DEPTH));

    // Head fields are forced to zero while empty so that stale slots never
    // leak onto the bus (and the outputs read zero straight out of reset).
    assign out_src   = out_valid ? mem_src[head_ptr]  : 3'd0;
    assign out_dest  = out_valid ? mem_dest[head_ptr] : 3'd0;
    assign out_dir   = out_valid ? mem_dir[head_ptr]  : 1'b0;

    // Duplicate search over live slots only. A slot is live when its distance
    // from the head is below count; the head slot leaving this cycle is not
    // considered stored, so an identical request pushed alongside its pop is
    // accepted.
    always_comb begin
        dup_hit  = 1'b0;
        dup_off  = '0;
        dup_live = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            dup_off  = AW'(i) - head_ptr;
            dup_live = ({1'b0, dup_off} < count_q) && !(pop && (AW'(i) == head_ptr));
            if (dup_live
                && (mem_src[i]  == src_input)
                && (mem_dest[i] == dest_input)
                && (mem_dir[i]  == direction_input)) begin
                dup_hit = 1'b1;
            end
        end
    end

    // Validation, first failing check wins. The full check looks at count
    // before any same-cycle pop, so a pop never rescues a push into a full queue.
    always_comb begin
        check_code = RC_NONE;
        if ((src_input > MAX_FL) || (dest_input > MAX_FL)) begin
            check_code = RC_RANGE;
        end else if (src_input == dest_input) begin
            check_code = RC_SAME;
        end else if (direction_input ? (dest_input <= src_input)
                                     : (dest_input >= src_input)) begin
            check_code = RC_DIR;
        end else if (count_q == CW'(DEPTH)) begin
            check_code = RC_FULL;
        end else if (dup_hit) begin
            check_code = RC_DUP;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1        <= 1'b0;
            sync2        <= 1'b0;
            sync3        <= 1'b0;
            head_ptr     <= '0;
            tail_ptr     <= '0;
            count_q      <= '0;
            reject_pulse <= 1'b0;
            reject_code  <= RC_NONE;
        end else begin
            sync1 <= set_clk;
            sync2 <= sync1;
            sync3 <= sync2;

            reject_pulse <= push_req && (check_code != RC_NONE);
            if (push_req && (check_code != RC_NONE)) begin
                reject_code <= check_code;
            end

            // Pointers wrap naturally because DEPTH is a power of two
            if (push_ok) begin
                tail_ptr <= tail_ptr + 1'b1;
            end
            if (pop) begin
                head_ptr <= head_ptr + 1'b1;
            end

            case ({push_ok, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: slots are only observed once written
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_src[tail_ptr]  <= src_input;
            mem_dest[tail_ptr] <= dest_input;
            mem_dir[tail_ptr]  <= direction_input;
        end
    end

endmodule

// File: tb/tb_ride_request_queue.sv
// tb/tb_ride_request_queue.sv - directed self-checking bench for ride_request_queue

`timescale 1ns/1ps

module tb_ride_request_queue;

    logic       clk;
    logic       rst;
    logic       set_clk;
    logic [2:0] src_input;
    logic [2:0] dest_input;
    logic       direction_input;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_src;
    logic [2:0] out_dest;
    logic       out_dir;
    logic [2:0] count;
    logic       full;
    logic       empty;
    logic       reject_pulse;
    logic [2:0] reject_code;

    int n_cmp  = 0;
    int n_fail = 0;

    logic       obs_valid_pre;
    logic       obs_valid3;
    logic       obs_pulse3;
    logic       obs_pulse4;
    logic [2:0] obs_count3;

    ride_request_queue #(.DEPTH(4), .MAX_FLOOR(5), .CW(3)) dut (
        .clk             (clk),
        .rst             (rst),
        .set_clk         (set_clk),
        .src_input       (src_input),
        .dest_input      (dest_input),
        .direction_input (direction_input),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_src         (out_src),
        .out_dest        (out_dest),
        .out_dir         (out_dir),
        .count           (count),
        .full            (full),
        .empty           (empty),
        .reject_pulse    (reject_pulse),
        .reject_code     (reject_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Raise set_clk right after a falling edge. Push lands on the 3rd rising
    // edge; observations are taken on the falling edges around it.
    task automatic strobe(input logic [2:0] s, input logic [2:0] d,
                          input logic dr, input logic pop_at_push);
        @(negedge clk);
        src_input       = s;
        dest_input      = d;
        direction_input = dr;
        set_clk         = 1'b1;
        @(negedge clk);
        @(negedge clk);
        obs_valid_pre = out_valid;
        if (pop_at_push) out_ready = 1'b1;
        @(negedge clk);
        out_ready  = 1'b0;
        obs_pulse3 = reject_pulse;
        obs_count3 = count;
        obs_valid3 = out_valid;
        @(negedge clk);
        obs_pulse4 = reject_pulse;
        set_clk    = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; set_clk = 1'b0; out_ready = 1'b0;
        src_input = 3'd0; dest_input = 3'd0; direction_input = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", count); end
        n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %0b want 1", empty); end
        n_cmp++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %0b want 0", full); end
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0b want 0", out_valid); end
        n_cmp++; if ({reject_pulse, reject_code} !== 4'd0) begin n_fail++; $display("FAIL reset_reject got %0b/%0d want 0/0", reject_pulse, reject_code); end
        n_cmp++; if ({out_src, out_dest, out_dir} !== 7'd0) begin n_fail++; $display("FAIL reset_head got %0d/%0d/%0b want 0/0/0", out_src, out_dest, out_dir); end
    endtask

    task automatic test_first_push();
        strobe(3'd4, 3'd2, 1'b0, 1'b0);
        n_cmp++; if (obs_valid_pre !== 1'b0) begin n_fail++; $display("FAIL first_valid_early got %0b want 0", obs_valid_pre); end
        n_cmp++; if (obs_valid3 !== 1'b1) begin n_fail++; $display("FAIL first_valid_latency got %0b want 1", obs_valid3); end
        n_cmp++; if ({out_src, out_dest, out_dir} !== {3'd4, 3'd2, 1'b0}) begin n_fail++; $display("FAIL first_head got %0d/%0d/%0b want 4/2/0", out_src, out_dest, out_dir); end
        n_cmp++; if (count !== 3'd1) begin n_fail++; $display("FAIL first_count got %0d want 1", count); end
    endtask

    task automatic test_fifo_order();
        repeat (50) @(negedge clk);
        strobe(3'd5, 3'd3, 1'b0, 1'b0);
        n_cmp++; if (count !== 3'd2) begin n_fail++; $display("FAIL order_count2 got %0d want 2", count); end
        n_cmp++; if ({out_src, out_dest, out_dir} !== {3'd4, 3'd2, 1'b0}) begin n_fail++; $display("FAIL order_head_stable got %0d/%0d/%0b want 4/2/0", out_src, out_dest, out_dir); end
        out_ready = 1'b1;
        @(negedge clk);
        n_cmp++; if ({out_src, out_dest, out_dir} !== {3'd5, 3'd3, 1'b0}) begin n_fail++; $display("FAIL order_head2 got %0d/%0d/%0b want 5/3/0", out_src, out_dest, out_dir); end
        n_cmp++; if (count !== 3'd1) begin n_fail++; $display("FAIL order_count1 got %0d want 1", count); end
        @(negedge clk);
        n_cmp++; if (count !== 3'd0 || empty !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL order_drained got count %0d empty %0b valid %0b want 0/1/0", count, empty, out_valid); end
        @(negedge clk);
        n_cmp++; if (count !== 3'd0) begin n_fail++; $display("FAIL order_ready_while_empty got %0d want 0", count); end
        out_ready = 1'b0;
    endtask

    task automatic test_rejects();
        logic [2:0] s_t [4];
        logic [2:0] d_t [4];
        logic [2:0] c_t [4];
        s_t = '{3'd6, 3'd3, 3'd2, 3'd4};
        d_t = '{3'd2, 3'd3, 3'd5, 3'd2};
        c_t = '{3'd1, 3'd2, 3'd3, 3'd5};
        strobe(3'd4, 3'd2, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            strobe(s_t[i], d_t[i], 1'b0, 1'b0);
            n_cmp++; if (obs_pulse3 !== 1'b1) begin n_fail++; $display("FAIL reject_pulse[%0d] got %0b want 1", i, obs_pulse3); end
            n_cmp++; if (obs_pulse4 !== 1'b0) begin n_fail++; $display("FAIL reject_pulse_width[%0d] got %0b want 0", i, obs_pulse4); end
            n_cmp++; if (reject_code !== c_t[i]) begin n_fail++; $display("FAIL reject_code[%0d] got %0d want %0d", i, reject_code, c_t[i]); end
            n_cmp++; if (count !== 3'd1) begin n_fail++; $display("FAIL reject_count[%0d] got %0d want 1", i, count); end
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reject_drain got empty %0b want 1", empty); end
    endtask

    task automatic test_full();
        for (int i = 1; i <= 4; i++) strobe(3'(i), 3'd0, 1'b0, 1'b0);
        n_cmp++; if (count !== 3'd4 || full !== 1'b1) begin n_fail++; $display("FAIL full_fill got count %0d full %0b want 4/1", count, full); end
        strobe(3'd5, 3'd0, 1'b0, 1'b0);
        n_cmp++; if (obs_pulse3 !== 1'b1 || reject_code !== 3'd4) begin n_fail++; $display("FAIL full_reject got pulse %0b code %0d want 1/4", obs_pulse3, reject_code); end
        n_cmp++; if (count !== 3'd4) begin n_fail++; $display("FAIL full_count_kept got %0d want 4", count); end
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        out_ready = 1'b0;
        n_cmp++; if (count !== 3'd2 || out_src !== 3'd3) begin n_fail++; $display("FAIL full_pop2 got count %0d src %0d want 2/3", count, out_src); end
        strobe(3'd5, 3'd1, 1'b0, 1'b1);
        n_cmp++; if (obs_pulse3 !== 1'b0 || obs_count3 !== 3'd2) begin n_fail++; $display("FAIL full_push_pop got pulse %0b count %0d want 0/2", obs_pulse3, obs_count3); end
        n_cmp++; if ({out_src, out_dest, out_dir} !== {3'd4, 3'd0, 1'b0}) begin n_fail++; $display("FAIL wrap_head1 got %0d/%0d/%0b want 4/0/0", out_src, out_dest, out_dir); end
        out_ready = 1'b1;
        @(negedge clk);
        n_cmp++; if ({out_src, out_dest, out_dir} !== {3'd5, 3'd1, 1'b0} || count !== 3'd1) begin n_fail++; $display("FAIL wrap_head2 got %0d/%0d/%0b count %0d want 5/1/0 count 1", out_src, out_dest, out_dir, count); end
        @(negedge clk);
        out_ready = 1'b0;
        n_cmp++; if (count !== 3'd0) begin n_fail++; $display("FAIL wrap_drain got %0d want 0", count); end
    endtask

    task automatic test_back_to_back();
        strobe(3'd1, 3'd0, 1'b0, 1'b0);
        strobe(3'd1, 3'd0, 1'b0, 1'b1);
        n_cmp++; if (obs_pulse3 !== 1'b0 || obs_count3 !== 3'd1) begin n_fail++; $display("FAIL dup_popped got pulse %0b count %0d want 0/1", obs_pulse3, obs_count3); end
        n_cmp++; if ({out_valid, out_src, out_dest, out_dir} !== {1'b1, 3'd1, 3'd0, 1'b0}) begin n_fail++; $display("FAIL dup_popped_head got %0b %0d/%0d/%0b want 1 1/0/0", out_valid, out_src, out_dest, out_dir); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        n_cmp++; if (count !== 3'd0) begin n_fail++; $display("FAIL b2b_drain got %0d want 0", count); end
    endtask

    task automatic test_reset_midway();
        strobe(3'd1, 3'd0, 1'b0, 1'b0);
        strobe(3'd2, 3'd0, 1'b0, 1'b0);
        strobe(3'd3, 3'd0, 1'b0, 1'b0);
        n_cmp++; if (count !== 3'd3 || out_valid !== 1'b1) begin n_fail++; $display("FAIL mid_pre got count %0d valid %0b want 3/1", count, out_valid); end
        @(negedge clk);
        src_input = 3'd2; dest_input = 3'd1; direction_input = 1'b0;
        set_clk = 1'b1;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (count !== 3'd0 || empty !== 1'b1 || full !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_async got count %0d empty %0b full %0b valid %0b want 0/1/0/0", count, empty, full, out_valid); end
        n_cmp++; if ({out_src, out_dest, out_dir, reject_pulse, reject_code} !== 11'd0) begin n_fail++; $display("FAIL mid_async_out got %0d/%0d/%0b pulse %0b code %0d want zeros", out_src, out_dest, out_dir, reject_pulse, reject_code); end
        set_clk = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        n_cmp++; if (count !== 3'd0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_no_push got count %0d valid %0b want 0/0", count, out_valid); end
    endtask

    initial begin
        test_reset();
        test_first_push();
        test_fifo_order();
        test_rejects();
        test_full();
        test_back_to_back();
        test_reset_midway();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ride_request_queue.md
Name: ride_request_queue

Overview:
- Front-end stage directly upstream of the elevator controller.
- Captures ride requests (source floor, destination floor, direction) presented with an asynchronous set strobe.
- Validates and buffers the requests in a FIFO, then delivers them to the controller over a valid/ready handshake.
- Lets requests arrive while the car is busy (moving, door open) without being lost.

Parameters:
- DEPTH, 4, FIFO entries; power of two, at least 2.
- MAX_FLOOR, 5, highest legal floor number; legal floors are 0..MAX_FLOOR.
- CW, 3, width of count output; must equal clog2(DEPTH)+1.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous active-high reset.
- set_clk  in  1  request strobe, asynchronous to clk; a rising edge submits one request.
- src_input  in  3  request source floor; must be stable from strobe rise + 3 clk.
- dest_input  in  3  request destination floor; same stability rule.
- direction_input  in  1  1 = up, 0 = down.
- out_valid  out  1  head entry is available.
- out_ready  in  1  controller accepts the head entry.
- out_src  out  3  head source floor.
- out_dest  out  3  head destination floor.
- out_dir  out  1  head direction.
- count  out  CW  number of stored entries.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- reject_pulse  out  1  one-cycle pulse when a submitted request is dropped.
- reject_code  out  3  reason for the last drop; holds until the next drop.

Behaviour:
- Reset (async, active-high):
  - Clear the pointers and set count = 0, so empty = 1 and full = 0.
  - out_valid = 0, reject_pulse = 0, reject_code = 0.
  - out_src, out_dest and out_dir = 0.
  - Clear the synchronizer and edge-detect flops.
  - Entries that are in flight are discarded.
- Strobe capture:
  - set_clk passes through a 2-flop synchronizer, then a third flop for edge detection.
  - A push request (one-cycle pulse) fires when sync2 = 1 and sync3 = 0.
  - The inputs are sampled in that cycle.
  - The push takes effect at the 3rd rising clk edge after set_clk rises; timing relative to the clk phase may add one edge.
  - A falling edge of set_clk does nothing.
  - A set_clk pulse shorter than one clk period may be missed; this is legal and not flagged.
- Validation: checked in the push cycle, first failing check wins.
  - Code 1: src_input > MAX_FLOOR or dest_input > MAX_FLOOR.
  - Code 2: src_input == dest_input.
  - Code 3: direction mismatch, i.e. direction_input = 1 with dest <= src, or direction_input = 0 with dest >= src.
  - Code 4: full, evaluated on count before any pop in the same cycle; a simultaneous pop does not rescue the push.
  - Code 5: exact duplicate ({src, dest, dir} identical) of any entry currently stored.
  - A rejected push: no state change except reject_pulse = 1 for one cycle and reject_code updated.
- Accepted push: write at the tail and increment the tail pointer, which wraps modulo DEPTH.
- Output handshake:
  - out_valid = !empty.
  - out_src, out_dest and out_dir are driven combinationally from the head entry.
  - They are stable while out_valid = 1 and out_ready = 0.
  - A pop occurs on a clk edge when out_valid && out_ready; the head pointer increments and wraps.
  - out_ready while empty is ignored.
- No bypass: a request pushed into an empty queue appears on out_valid the cycle after the write edge.
- count:
  - Push only: +1. Pop only: -1.
  - Push and pop in the same cycle: unchanged. Head and tail both advance, so this is legal even at count = 1.
  - count never exceeds DEPTH and never underflows.
- Delivery order is strict FIFO; no reordering or merging.
- Duplicate check compares against valid entries only, never stale slots.
- An entry popped in the same cycle as a push of an identical request does not count as stored, so that push is accepted.

Test Plan:
- Reset, then strobe 4->2 dir 0, out_ready = 0 -> out_valid rises 3–4 clk after strobe; head = (4, 2, 0); count = 1.
- Strobe 4->2 down, then 5->3 down 50 cycles later, out_ready = 0; then assert out_ready -> pops deliver (4, 2, 0) then (5, 3, 0); count 2->1->0; empty = 1.
- Illegal requests 6->2, 3->3, 2->5 with dir 0, and a duplicate 4->2 while 4->2 is stored -> reject_code 1, 2, 3, 5 respectively; reject_pulse 1 clk each; count unchanged.
- Fill 4 legal distinct requests, strobe a 5th -> full = 1, reject_code 4; hold out_ready high with a push in the same cycle at count = 2 -> count stays 2 and order is preserved across pointer wrap.
- Assert rst mid-way (count = 3, out_valid = 1, strobe in synchronizer) -> all outputs at reset values immediately; no push from the pending strobe after release.
